// File: rtl/three_row_feeder.sv
// three_row_feeder: four-bank row buffer that offers sliding three-row windows to the 3x3 window builder
//   clk, rst_n              clock, asynchronous active-low reset
//   Start                   frame start, honoured only while idle
//   Row_Num_After_Padding   padded row/column count R (R >= 3)
//   Channel_In_Num_REG      input channel count, multiple of CHANNEL_IN_NUM
//   S_Data/S_Valid/S_Ready  incoming beat stream, column-major, channel group fastest
//   Row_Compute_Sign        three consecutive rows resident and offered
//   Read_Active/Read_Addr   builder busy flag and read address
//   M_Feature               {row w+2, row w+1, row w}, one cycle after Read_Addr
//   Frame_Done              one-cycle pulse after the last window is released
`ifndef WIDTH_DATA
`define WIDTH_DATA 8
`endif
`ifndef PICTURE_NUM
`define PICTURE_NUM 1
`endif
module three_row_feeder #(
  parameter int CHANNEL_IN_NUM = 16,
  parameter int WIDTH_RAM_SIZE = 12,
  parameter int WIDTH_FEATURE_SIZE = 12,
  parameter int WIDTH_CHANNEL_NUM = 10,
  localparam int Width_Data = `WIDTH_DATA*`PICTURE_NUM*CHANNEL_IN_NUM
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          Start,
  input  logic [WIDTH_FEATURE_SIZE-1:0] Row_Num_After_Padding,
  input  logic [WIDTH_CHANNEL_NUM-1:0]  Channel_In_Num_REG,
  input  logic [Width_Data-1:0]         S_Data,
  input  logic                          S_Valid,
  output logic                          S_Ready,
  output logic                          Row_Compute_Sign,
  input  logic                          Read_Active,
  input  logic [WIDTH_RAM_SIZE-1:0]     Read_Addr,
  output logic [3*Width_Data-1:0]       M_Feature,
  output logic                          Frame_Done
);
  localparam int DEPTH = 1 << WIDTH_RAM_SIZE;
  typedef enum logic {F_IDLE, F_RUN} frame_t;
  typedef enum logic [1:0] {W_WAIT, W_SIGNAL, W_BUSY} win_t;
  frame_t frame_q, frame_d;
  win_t win_q, win_d;
  logic [WIDTH_FEATURE_SIZE-1:0] wr_row_q, wr_row_d, win_row_q, win_row_d;
  logic [WIDTH_RAM_SIZE-1:0] wr_addr_q, wr_addr_d, w, w_last;
  logic [WIDTH_CHANNEL_NUM-1:0] grp;
  logic ra_q, done_q, done_d;
  logic run, accept, ra_rise, ra_fall, last_win, row_end;
  logic [2:0][Width_Data-1:0] feat_q;
  logic [Width_Data-1:0] mem [4][DEPTH];
  assign grp = Channel_In_Num_REG / WIDTH_CHANNEL_NUM'(CHANNEL_IN_NUM);
  assign w = WIDTH_RAM_SIZE'(Row_Num_After_Padding) * WIDTH_RAM_SIZE'(grp);
  assign w_last = w - WIDTH_RAM_SIZE'(1);
  assign run = frame_q == F_RUN;
  // staying within four rows of the window base keeps the write bank out of the three read banks
  assign S_Ready = run && wr_row_q < Row_Num_After_Padding && wr_row_q < win_row_q + WIDTH_FEATURE_SIZE'(4);
  assign accept = S_Valid && S_Ready;
  assign row_end = wr_addr_q == w_last;
  assign ra_rise = Read_Active && !ra_q;
  assign ra_fall = !Read_Active && ra_q;
  assign last_win = win_row_q == Row_Num_After_Padding - WIDTH_FEATURE_SIZE'(3);
  assign Row_Compute_Sign = win_q == W_SIGNAL;
  assign M_Feature = feat_q;
  assign Frame_Done = done_q;
  always_comb begin
    frame_d = frame_q;
    win_d = win_q;
    wr_row_d = wr_row_q;
    wr_addr_d = wr_addr_q;
    win_row_d = win_row_q;
    done_d = 1'b0;
    if (!run) begin
      if (Start) begin
        frame_d = F_RUN;
        win_d = W_WAIT;
        wr_row_d = '0;
        wr_addr_d = '0;
        win_row_d = '0;
      end
    end else begin
      if (accept) begin
        wr_addr_d = row_end ? '0 : wr_addr_q + WIDTH_RAM_SIZE'(1);
        wr_row_d = row_end ? wr_row_q + WIDTH_FEATURE_SIZE'(1) : wr_row_q;
      end
      if (win_q == W_WAIT && wr_row_q >= win_row_q + WIDTH_FEATURE_SIZE'(3)) win_d = W_SIGNAL;
      if (win_q == W_SIGNAL && ra_rise) win_d = W_BUSY;
      if (win_q == W_BUSY && ra_fall) begin
        win_d = W_WAIT;
        frame_d = last_win ? F_IDLE : F_RUN;
        done_d = last_win;
        win_row_d = last_win ? win_row_q : win_row_q + WIDTH_FEATURE_SIZE'(1);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= F_IDLE;
      win_q <= W_WAIT;
      wr_row_q <= '0;
      wr_addr_q <= '0;
      win_row_q <= '0;
      ra_q <= 1'b0;
      done_q <= 1'b0;
      feat_q <= '0;
    end else begin
      frame_q <= frame_d;
      win_q <= win_d;
      wr_row_q <= wr_row_d;
      wr_addr_q <= wr_addr_d;
      win_row_q <= win_row_d;
      ra_q <= Read_Active;
      done_q <= done_d;
      for (int k = 0; k < 3; k++) feat_q[k] <= mem[win_row_q[1:0] + 2'(k)][Read_Addr];
    end
  end
  always_ff @(posedge clk) if (accept) mem[wr_row_q[1:0]][wr_addr_q] <= S_Data;
endmodule

// File: tb/tb_three_row_feeder.sv
// tb_three_row_feeder: directed self-checking bench for three_row_feeder
module tb_three_row_feeder;
  logic clk = 1'b0, rst_n = 1'b0, Start = 1'b0, S_Valid = 1'b0, Read_Active = 1'b0;
  logic S_Ready, Row_Compute_Sign, Frame_Done;
  logic [11:0] Row_Num_After_Padding = 12'd5;
  logic [9:0] Channel_In_Num_REG = 10'd16;
  logic [127:0] S_Data = '0;
  logic [11:0] Read_Addr = '0;
  logic [383:0] M_Feature;
  int checks = 0, errors = 0, sent = 0;
  always #5 clk = ~clk;
  three_row_feeder dut (
    .clk(clk), .rst_n(rst_n), .Start(Start),
    .Row_Num_After_Padding(Row_Num_After_Padding), .Channel_In_Num_REG(Channel_In_Num_REG),
    .S_Data(S_Data), .S_Valid(S_Valid), .S_Ready(S_Ready),
    .Row_Compute_Sign(Row_Compute_Sign), .Read_Active(Read_Active), .Read_Addr(Read_Addr),
    .M_Feature(M_Feature), .Frame_Done(Frame_Done)
  );
  function automatic logic [127:0] mk(input int v);
    return {16{v[7:0]}};
  endfunction
  function automatic logic [383:0] win(input int n, input int a);
    return {mk(16*(n+2)+a), mk(16*(n+1)+a), mk(16*n+a)};
  endfunction
  task automatic check_idle_outputs(input string tag);
    checks++; if (S_Ready !== 1'b0) begin errors++; $display("FAIL %s S_Ready got %b exp 0", tag, S_Ready); end
    checks++; if (Row_Compute_Sign !== 1'b0) begin errors++; $display("FAIL %s Row_Compute_Sign got %b exp 0", tag, Row_Compute_Sign); end
    checks++; if (M_Feature !== '0) begin errors++; $display("FAIL %s M_Feature got %h exp 0", tag, M_Feature); end
    checks++; if (Frame_Done !== 1'b0) begin errors++; $display("FAIL %s Frame_Done got %b exp 0", tag, Frame_Done); end
  endtask
  task automatic start_frame(input int r, input int ch);
    Row_Num_After_Padding = 12'(r);
    Channel_In_Num_REG = 10'(ch);
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    checks++; if (S_Ready !== 1'b1) begin errors++; $display("FAIL start_ready got %b exp 1", S_Ready); end
  endtask
  task automatic stream(input int w, input int total, input bit gap, input bit poke, input bit chk15);
    int g = 0;
    sent = 0;
    while (sent < total && g < 3000) begin
      @(negedge clk);
      g++;
      if (chk15 && sent == 15) begin
        checks++; if (Row_Compute_Sign !== 1'b0) begin errors++; $display("FAIL rcs_after_beat14 got %b exp 0", Row_Compute_Sign); end
      end
      if (chk15 && sent == 16) begin
        checks++; if (Row_Compute_Sign !== 1'b1) begin errors++; $display("FAIL rcs_after_beat15 got %b exp 1", Row_Compute_Sign); end
      end
      Start = poke && (g % 3 == 0);
      if (gap && g[0]) begin
        S_Valid = 1'b0;
        continue;
      end
      S_Valid = 1'b1;
      S_Data = mk(16*(sent/w) + sent%w);
      if (S_Ready) sent++;
    end
    @(negedge clk);
    S_Valid = 1'b0;
    Start = 1'b0;
    checks++; if (sent != total) begin errors++; $display("FAIL stream_count got %0d exp %0d", sent, total); end
  endtask
  task automatic serve(input int r, input int w, input bit bp);
    for (int n = 0; n <= r - 3; n++) begin
      int g = 0;
      while (!Row_Compute_Sign && g < 3000) begin
        @(negedge clk);
        g++;
      end
      checks++; if (Row_Compute_Sign !== 1'b1) begin errors++; $display("FAIL rcs_wait win %0d got %b exp 1", n, Row_Compute_Sign); end
      Read_Active = 1'b1;
      @(negedge clk);
      checks++; if (Row_Compute_Sign !== 1'b0) begin errors++; $display("FAIL rcs_fall win %0d got %b exp 0", n, Row_Compute_Sign); end
      for (int a = 0; a < w; a++) begin
        Read_Addr = 12'(a);
        @(negedge clk);
        checks++;
        if (M_Feature !== win(n, a)) begin
          errors++;
          $display("FAIL feature win %0d addr %0d got %h exp %h", n, a, M_Feature, win(n, a));
        end
      end
      if (bp && n == 0) begin
        checks++; if (S_Ready !== 1'b0) begin errors++; $display("FAIL bp_hold got %b exp 0", S_Ready); end
      end
      Read_Active = 1'b0;
      @(negedge clk);
      checks++;
      if (Frame_Done !== (n == r - 3)) begin errors++; $display("FAIL frame_done win %0d got %b exp %b", n, Frame_Done, n == r - 3); end
      if (bp && n == 0) begin
        checks++; if (S_Ready !== 1'b1) begin errors++; $display("FAIL bp_recover got %b exp 1", S_Ready); end
      end
    end
    @(negedge clk);
    checks++; if (Frame_Done !== 1'b0) begin errors++; $display("FAIL frame_done_pulse got %b exp 0", Frame_Done); end
  endtask
  task automatic run_frame(input int r, input int ch, input bit gap, input bit poke, input bit bp, input bit chk15);
    int w = r * (ch / 16);
    start_frame(r, ch);
    fork
      stream(w, r * w, gap, poke, chk15);
      begin
        if (bp) begin
          repeat (60) @(negedge clk);
          checks++; if (sent != 28) begin errors++; $display("FAIL bp_beats got %0d exp 28", sent); end
          checks++; if (S_Ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %b exp 0", S_Ready); end
        end
        serve(r, w, bp);
      end
    join
  endtask
  task automatic test_reset();
    @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("idle");
  endtask
  task automatic test_basic();
    run_frame(5, 16, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask
  task automatic test_backpressure_wrap();
    run_frame(7, 16, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask
  task automatic test_two_groups();
    run_frame(4, 32, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic test_toggle_start();
    run_frame(5, 16, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic test_reset_midframe();
    start_frame(5, 16);
    for (int b = 0; b < 12; b++) begin
      S_Valid = 1'b1;
      S_Data = mk(16*(b/5) + b%5 + 8'h80);
      @(negedge clk);
    end
    S_Valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("midreset");
    @(negedge clk);
    check_idle_outputs("midreset_hold");
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(5, 16, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask
  initial begin
    test_reset();
    test_basic();
    test_backpressure_wrap();
    test_two_groups();
    test_toggle_start();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
